cosine_vec_loader: RTL

COSINE_VEC_LOADER -- requirements
Module: cosine_vec_loader

---
 rtl/cosine_pkg.sv | 16 +
 rtl/cosine_vec_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cosine_pkg.sv
// Shared definitions for the cosine-similarity datapath: fixed-point format,
// default element width and the loader state encoding.
package cosine_pkg;

  localparam int unsigned FRAC       = 15;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StFire,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/cosine_vec_loader.sv
// Streams 2*W beats into vec_a/vec_b, kicks cosine_sim with a one-cycle start, then
// waits (bounded) for its result and presents it on a valid/ready channel.
module cosine_vec_loader
  import cosine_pkg::*;
#(
  parameter int unsigned W       = 5,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [DATA_W-1:0] vec_a [W],
  output logic [DATA_W-1:0] vec_b [W],
  output logic              start,
  input  logic              sim_valid,
  input  logic [DATA_W-1:0] sim_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [15:0]       res_idx,
  output logic              err_frame,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic              busy
);

  localparam int unsigned BeatW = $clog2(2 * W + 1);
  localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BeatW-1:0] LastA    = BeatW'(W - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(2 * W - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]  vec_a_q [W];
  logic [DATA_W-1:0]  vec_a_d [W];
  logic [DATA_W-1:0]  vec_b_q [W];
  logic [DATA_W-1:0]  vec_b_d [W];
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic [15:0]        res_idx_q, res_idx_d;
  logic               err_frame_q, err_frame_d;
  logic               err_timeout_q, err_timeout_d;
  logic               frame_set, tmo_set, beat_fire;

  // Gated by rst so nothing is accepted during the reset cycle itself.
  assign in_ready  = !rst && (state_q == StLoadA || state_q == StLoadB);
  assign beat_fire = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    vec_a_d    = vec_a_q;
    vec_b_d    = vec_b_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    frame_set  = 1'b0;
    tmo_set    = 1'b0;

    unique case (state_q)
      StLoadA: begin
        if (beat_fire) begin
          if (in_last) begin
            // Early in_last: drop the partial pair and resynchronise.
            frame_set = 1'b1;
            beat_d    = '0;
          end else begin
            for (int k = 0; k < W; k++) begin
              if (beat_q == BeatW'(k)) vec_a_d[k] = in_data;
            end
            beat_d = beat_q + 1'b1;
            if (beat_q == LastA) state_d = StLoadB;
          end
        end
      end
      StLoadB: begin
        if (beat_fire) begin
          if (beat_q == LastBeat || !in_last) begin
            for (int k = 0; k < W; k++) begin
              if (beat_q == BeatW'(W + k)) vec_b_d[k] = in_data;
            end
          end
          if (beat_q == LastBeat) begin
            // A missing in_last is flagged but the pair still fires.
            frame_set = !in_last;
            beat_d    = '0;
            state_d   = StFire;
          end else if (in_last) begin
            frame_set = 1'b1;
            beat_d    = '0;
            state_d   = StLoadA;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StFire: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (sim_valid) begin
          res_data_d = sim_data;
          state_d    = StResp;
        end else if (tmo_q == TmoLast) begin
          tmo_set = 1'b1;
          state_d = StLoadA;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp: begin
        if (res_ready) begin
          res_idx_d = res_idx_q + 16'd1;
          state_d   = StLoadA;
        end
      end
      default: state_d = StLoadA;
    endcase

    err_frame_d   = (err_frame_q & ~err_clr) | frame_set;
    err_timeout_d = (err_timeout_q & ~err_clr) | tmo_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StLoadA;
      beat_q        <= '0;
      tmo_q         <= '0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      for (int k = 0; k < W; k++) begin
        vec_a_q[k] <= '0;
        vec_b_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      for (int k = 0; k < W; k++) begin
        vec_a_q[k] <= vec_a_d[k];
        vec_b_q[k] <= vec_b_d[k];
      end
    end
  end

  assign vec_a       = vec_a_q;
  assign vec_b       = vec_b_q;
  assign start       = !rst && (state_q == StFire);
  assign res_valid   = (state_q == StResp);
  assign res_data    = res_data_q;
  assign res_idx     = res_idx_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;
  assign busy        = !(state_q == StLoadA && beat_q == '0);

endmodule
